// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU select encodings and the EX-stage control
// record together with its bubble value.
package pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MUL  = 4'b0010,
        ALU_SRL  = 4'b0100,
        ALU_AND  = 4'b0101,
        ALU_SRLV = 4'b0110,
        ALU_SRAV = 4'b0111,
        ALU_OR   = 4'b1001
    } alu_sel_e;

    localparam int REG_W = 5;

    // Control half of the EX register; the data half depends on WIDTH.
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_read;
        logic             use_imm;
        logic [3:0]       alu_sel;
        logic [4:0]       shamt;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        valid:     1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        use_imm:   1'b0,
        alu_sel:   ALU_ADD,
        shamt:     5'd0,
        rs:        5'd0,
        rt:        5'd0,
        rd:        5'd0
    };

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register; EX/MEM wins over MEM/WB
// and register 0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic [WIDTH-1:0] reg_data,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] fwd_data
);

    logic hit_exmem, hit_memwb;

    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src_reg);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src_reg);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem)
            fwd_data = exmem_result;
        else if (hit_memwb)
            fwd_data = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and combinational
// operand forwarding into the ALU.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_use_imm,
    input  logic             id_mem_read,
    input  logic             id_reg_write,
    input  logic [3:0]       id_alu_sel,
    input  logic [4:0]       id_shamt,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    input  logic             ext_stall,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [3:0]       alu_sel,
    output logic [4:0]       alu_shamt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             ex_valid,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [4:0]       ex_rd,
    output logic [WIDTH-1:0] ex_store_data,
    output logic             hazard_stall
);

    ex_ctrl_t         ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rs_data_q, rs_data_d;
    logic [WIDTH-1:0] rt_data_q, rt_data_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // A frozen back end cannot accept the bubble, so the load-use stall is muted.
    assign hazard_stall = !ext_stall && id_valid && ctrl_q.valid && ctrl_q.mem_read &&
                          (ctrl_q.rd != '0) && ((ctrl_q.rd == id_rs) || (ctrl_q.rd == id_rt));

    always_comb begin
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (!ext_stall) begin
            if (flush || hazard_stall) begin
                ctrl_d    = EX_CTRL_BUBBLE;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
            end else begin
                ctrl_d.valid     = id_valid;
                ctrl_d.reg_write = id_reg_write;
                ctrl_d.mem_read  = id_mem_read;
                ctrl_d.use_imm   = id_use_imm;
                ctrl_d.alu_sel   = id_alu_sel;
                ctrl_d.shamt     = id_shamt;
                ctrl_d.rs        = id_rs;
                ctrl_d.rt        = id_rt;
                ctrl_d.rd        = id_rd;
                rs_data_d        = id_rs_data;
                rt_data_d        = id_rt_data;
                imm_d            = id_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= EX_CTRL_BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    fwd_unit #(.WIDTH(WIDTH)) u_fwd_rs (
        .src_reg         (ctrl_q.rs),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rs)
    );

    fwd_unit #(.WIDTH(WIDTH)) u_fwd_rt (
        .src_reg         (ctrl_q.rt),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_rt)
    );

    assign alu_sel       = ctrl_q.alu_sel;
    assign alu_shamt     = ctrl_q.shamt;
    assign alu_a         = fwd_rs;
    assign alu_b         = ctrl_q.use_imm ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_rd         = ctrl_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: pipeline load, forwarding priority,
// load-use stall, flush/freeze ordering, immediates and async reset.
module tb_id_ex_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid, id_use_imm, id_mem_read, id_reg_write;
    logic [3:0]       id_alu_sel;
    logic [4:0]       id_shamt;
    logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             flush, ext_stall;
    logic             exmem_reg_write, memwb_reg_write;
    logic [4:0]       exmem_rd, memwb_rd;
    logic [WIDTH-1:0] exmem_result, memwb_result;
    logic [3:0]       alu_sel;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_a, alu_b, ex_store_data;
    logic             ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0]       ex_rd;
    logic             hazard_stall;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_use_imm(id_use_imm), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_alu_sel(id_alu_sel), .id_shamt(id_shamt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .ext_stall(ext_stall),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_sel(alu_sel), .alu_shamt(alu_shamt), .alu_a(alu_a), .alu_b(alu_b),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [3:0] sel, input logic [4:0] rs,
                          input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic mr, input logic rw);
        id_valid = v; id_alu_sel = sel; id_rs = rs; id_rs_data = rsd;
        id_rt = rt; id_rt_data = rtd; id_rd = rd; id_mem_read = mr; id_reg_write = rw;
        id_use_imm = 1'b0; id_imm = '0; id_shamt = '0;
    endtask

    task automatic fwd_clear();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ext_stall = 1'b0;
        id_set(1'b0, 4'b0000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        fwd_clear();
        #2;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Plain ADD, one-cycle latency
        id_set(1'b1, 4'b0000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 1'b0, 1'b1);
        step();
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_sel", {28'd0, alu_sel}, 32'd0);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_rd", {27'd0, ex_rd}, 32'd5);

        // Forwarding priority on rs=3, rt=6
        id_set(1'b1, 4'b0001, 5'd3, 32'hAA, 5'd6, 32'hBB, 5'd9, 1'b0, 1'b1);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h20;
        #1;
        chk("fwd_exmem_wins", alu_a, 32'h10);
        chk("fwd_rt_nohit", alu_b, 32'hBB);
        exmem_rd = 5'd0; #1;
        chk("fwd_memwb", alu_a, 32'h20);
        exmem_rd = 5'd3; exmem_reg_write = 1'b0; #1;
        chk("fwd_exmem_nowrite", alu_a, 32'h20);
        memwb_rd = 5'd6; #1;
        chk("fwd_rt_memwb", alu_b, 32'h20);
        chk("fwd_rs_reg", alu_a, 32'hAA);
        fwd_clear();

        // Register 0 never forwards even if the EX instruction names it
        id_set(1'b1, 4'b0000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 1'b0, 1'b1);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        #1;
        chk("fwd_r0", alu_a, 32'h0);
        fwd_clear();

        // Load-use: load into r4, then consumer of r4
        id_set(1'b1, 4'b0000, 5'd1, 32'h100, 5'd0, 32'h0, 5'd4, 1'b1, 1'b1);
        step();
        chk("load_mem_read", {31'd0, ex_mem_read}, 32'd1);
        id_set(1'b1, 4'b0101, 5'd4, 32'h1, 5'd9, 32'h2, 5'd12, 1'b0, 1'b1);
        #1;
        chk("hz_rs", {31'd0, hazard_stall}, 32'd1);
        ext_stall = 1'b1; #1;
        chk("hz_masked", {31'd0, hazard_stall}, 32'd0);
        ext_stall = 1'b0; #1;
        step();
        chk("hz_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("hz_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("hz_bubble_sel", {28'd0, alu_sel}, 32'd0);
        chk("hz_cleared", {31'd0, hazard_stall}, 32'd0);
        step();
        chk("hz_consumer", {28'd0, alu_sel}, 32'd5);

        // Load-use through rt
        id_set(1'b1, 4'b0000, 5'd1, 32'h0, 5'd0, 32'h0, 5'd7, 1'b1, 1'b1);
        step();
        id_set(1'b1, 4'b0000, 5'd2, 32'h0, 5'd7, 32'h0, 5'd8, 1'b0, 1'b1);
        #1;
        chk("hz_rt", {31'd0, hazard_stall}, 32'd1);
        id_valid = 1'b0; #1;
        chk("hz_id_invalid", {31'd0, hazard_stall}, 32'd0);

        // ext_stall beats flush; held instruction re-evaluates forwarding
        id_set(1'b1, 4'b1001, 5'd10, 32'h33, 5'd11, 32'h44, 5'd8, 1'b0, 1'b1);
        step();
        id_set(1'b1, 4'b0010, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b0, 1'b1);
        flush = 1'b1; ext_stall = 1'b1;
        step();
        chk("hold_valid", {31'd0, ex_valid}, 32'd1);
        chk("hold_sel", {28'd0, alu_sel}, 32'h9);
        chk("hold_alu_a", alu_a, 32'h33);
        chk("hold_rd", {27'd0, ex_rd}, 32'd8);
        exmem_reg_write = 1'b1; exmem_rd = 5'd10; exmem_result = 32'h77; #1;
        chk("hold_refwd", alu_a, 32'h77);
        fwd_clear();
        ext_stall = 1'b0;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_alu_a", alu_a, 32'h0);
        chk("flush_rd", {27'd0, ex_rd}, 32'd0);
        flush = 1'b0;

        // Immediate operand; store data still sees forwarded rt
        id_set(1'b1, 4'b0000, 5'd12, 32'h2, 5'd11, 32'h1, 5'd0, 1'b0, 1'b0);
        id_use_imm = 1'b1; id_imm = 32'hFFFF_FFFC;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd11; exmem_result = 32'h9; #1;
        chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        chk("imm_store", ex_store_data, 32'h9);
        chk("imm_alu_a", alu_a, 32'h2);
        fwd_clear();

        // Asynchronous mid-cycle reset
        id_set(1'b1, 4'b0100, 5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 1'b0, 1'b1);
        id_shamt = 5'd4;
        step();
        chk("pre_rst_sel", {28'd0, alu_sel}, 32'h4);
        chk("pre_rst_shamt", {27'd0, alu_shamt}, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_sel", {28'd0, alu_sel}, 32'd0);
        chk("arst_rw", {31'd0, ex_reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("resume_valid", {31'd0, ex_valid}, 32'd1);
        chk("resume_sel", {28'd0, alu_sel}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
